// File: rtl/out_dma.sv
// AXI4 write-master DMA: drains output-buffer words to system memory in INCR bursts
// that never cross a 4KB boundary, with one burst outstanding at a time.
module out_dma #(
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_DATA_W = 64,
    parameter int AXI_ID_W   = 4,
    parameter int STREAM_ID  = 2,
    parameter int BURST_LEN  = 15,
    parameter int BUF_ADDR_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [AXI_ADDR_W-1:0]   dst_addr,
    input  logic [31:0]             transfer_length,
    output logic                    done,
    output logic                    busy,
    output logic                    error,
    output logic [AXI_ID_W-1:0]     m_axi_awid,
    output logic [AXI_ADDR_W-1:0]   m_axi_awaddr,
    output logic [7:0]              m_axi_awlen,
    output logic [2:0]              m_axi_awsize,
    output logic [1:0]              m_axi_awburst,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [AXI_DATA_W-1:0]   m_axi_wdata,
    output logic [AXI_DATA_W/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wlast,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [AXI_ID_W-1:0]     m_axi_bid,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic                    buf_re,
    output logic [BUF_ADDR_W-1:0]   buf_addr,
    input  logic [AXI_DATA_W-1:0]   buf_rdata
);
    localparam int STRB_W = AXI_DATA_W / 8;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_SEND_ADDR  = 3'd1,
        S_WRITE_DATA = 3'd2,
        S_WAIT_RESP  = 3'd3,
        S_DONE       = 3'd4
    } state_t;

    // awlen = min(BURST_LEN, beats-1, beats left in the 4KB page - 1); addr is 8-byte aligned.
    function automatic logic [7:0] calc_awlen(input logic [8:0] page_beat, input logic [31:0] rem);
        logic [32:0] beats_m1;
        logic [32:0] len_m1;
        logic [9:0]  room_m1;
        beats_m1 = (({1'b0, rem} + 33'd7) >> 3) - 33'd1;
        room_m1  = 10'd511 - {1'b0, page_beat};
        len_m1   = 33'(BURST_LEN);
        if (beats_m1 < len_m1) begin
            len_m1 = beats_m1;
        end else begin
            len_m1 = len_m1;
        end
        if ({23'd0, room_m1} < len_m1) begin
            len_m1 = {23'd0, room_m1};
        end else begin
            len_m1 = len_m1;
        end
        return len_m1[7:0];
    endfunction

    state_t                  state_q, state_d;
    logic [AXI_ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]             rem_q, rem_d;
    logic [7:0]              awlen_q, awlen_d;
    logic                    awvalid_q, awvalid_d;
    logic                    bready_q, bready_d;
    logic                    done_q, done_d;
    logic                    busy_q, busy_d;
    logic                    error_q, error_d;
    logic [BUF_ADDR_W-1:0]   buf_addr_q, buf_addr_d;
    logic [8:0]              fetch_cnt_q, fetch_cnt_d;
    logic [7:0]              sent_cnt_q, sent_cnt_d;
    logic                    rd_inflight_q, rd_inflight_d;
    logic [AXI_DATA_W-1:0]   fifo_mem_q [2];
    logic [AXI_DATA_W-1:0]   fifo_mem_d [2];
    logic                    fifo_wr_q, fifo_wr_d;
    logic                    fifo_rd_q, fifo_rd_d;
    logic [1:0]              fifo_cnt_q, fifo_cnt_d;

    logic [31:0]             burst_bytes_s;
    logic [31:0]             rem_after_s;
    logic [AXI_ADDR_W-1:0]   addr_after_s;
    logic                    w_valid_s;
    logic                    w_pop_s;
    logic                    fetch_s;
    logic                    last_beat_s;
    logic                    partial_s;
    logic                    unused_s;

    assign burst_bytes_s = {20'd0, ({1'b0, awlen_q} + 9'd1), 3'b000};
    assign rem_after_s   = (rem_q > burst_bytes_s) ? (rem_q - burst_bytes_s) : 32'd0;
    assign addr_after_s  = addr_q + AXI_ADDR_W'(burst_bytes_s);
    assign w_valid_s     = (fifo_cnt_q != 2'd0);
    assign w_pop_s       = w_valid_s && m_axi_wready;
    assign last_beat_s   = (sent_cnt_q == awlen_q);
    assign partial_s     = (rem_q <= burst_bytes_s) && last_beat_s && (rem_q[2:0] != 3'd0);
    // Counting this cycle's pop lets the 2-entry FIFO sustain one beat per clock.
    assign fetch_s       = (state_q == S_WRITE_DATA) && (fetch_cnt_q <= {1'b0, awlen_q}) &&
                           (({1'b0, fifo_cnt_q} + {2'b00, rd_inflight_q} - {2'b00, w_pop_s}) < 3'd2);
    assign unused_s      = ^m_axi_bid;

    assign done          = done_q;
    assign busy          = busy_q;
    assign error         = error_q;
    assign m_axi_awid    = AXI_ID_W'(STREAM_ID);
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = awlen_q;
    assign m_axi_awsize  = 3'b011;
    assign m_axi_awburst = 2'b01;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wvalid  = w_valid_s;
    assign m_axi_wdata   = fifo_mem_q[fifo_rd_q];
    assign m_axi_wlast   = w_valid_s && last_beat_s;
    assign m_axi_wstrb   = !w_valid_s ? {STRB_W{1'b0}} :
                           partial_s  ? ((STRB_W'(1) << rem_q[2:0]) - STRB_W'(1)) : {STRB_W{1'b1}};
    assign m_axi_bready  = bready_q;
    assign buf_re        = fetch_s;
    assign buf_addr      = buf_addr_q;

    // Next-state logic for the control FSM, read pipeline and data FIFO.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        rem_d         = rem_q;
        awlen_d       = awlen_q;
        awvalid_d     = awvalid_q;
        bready_d      = bready_q;
        done_d        = 1'b0;
        busy_d        = busy_q;
        error_d       = error_q;
        buf_addr_d    = buf_addr_q;
        fetch_cnt_d   = fetch_cnt_q;
        sent_cnt_d    = sent_cnt_q;
        rd_inflight_d = fetch_s;
        fifo_mem_d    = fifo_mem_q;
        fifo_wr_d     = fifo_wr_q;
        fifo_rd_d     = fifo_rd_q;
        fifo_cnt_d    = fifo_cnt_q + {1'b0, rd_inflight_q} - {1'b0, w_pop_s};

        if (rd_inflight_q) begin
            fifo_mem_d[fifo_wr_q] = buf_rdata;
            fifo_wr_d             = ~fifo_wr_q;
        end else begin
            fifo_wr_d = fifo_wr_q;
        end
        if (w_pop_s) begin
            fifo_rd_d = ~fifo_rd_q;
        end else begin
            fifo_rd_d = fifo_rd_q;
        end
        if (fetch_s) begin
            fetch_cnt_d = fetch_cnt_q + 9'd1;
            buf_addr_d  = buf_addr_q + BUF_ADDR_W'(1);
        end else begin
            fetch_cnt_d = fetch_cnt_q;
        end

        case (state_q)
            S_IDLE: begin
                if (start && (transfer_length == 32'd0)) begin
                    done_d  = 1'b1;
                    error_d = 1'b0;
                end else if (start && (dst_addr[2:0] != 3'd0)) begin
                    done_d  = 1'b1;
                    error_d = 1'b1;
                end else if (start) begin
                    addr_d      = dst_addr;
                    rem_d       = transfer_length;
                    awlen_d     = calc_awlen(dst_addr[11:3], transfer_length);
                    awvalid_d   = 1'b1;
                    busy_d      = 1'b1;
                    error_d     = 1'b0;
                    buf_addr_d  = {BUF_ADDR_W{1'b0}};
                    fetch_cnt_d = 9'd0;
                    sent_cnt_d  = 8'd0;
                    state_d     = S_SEND_ADDR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SEND_ADDR: begin
                if (awvalid_q && m_axi_awready) begin
                    awvalid_d = 1'b0;
                    state_d   = S_WRITE_DATA;
                end else begin
                    state_d = S_SEND_ADDR;
                end
            end
            S_WRITE_DATA: begin
                if (w_pop_s && last_beat_s) begin
                    sent_cnt_d = 8'd0;
                    bready_d   = 1'b1;
                    state_d    = S_WAIT_RESP;
                end else if (w_pop_s) begin
                    sent_cnt_d = sent_cnt_q + 8'd1;
                end else begin
                    sent_cnt_d = sent_cnt_q;
                end
            end
            S_WAIT_RESP: begin
                if (bready_q && m_axi_bvalid && (m_axi_bresp != 2'b00)) begin
                    bready_d = 1'b0;
                    error_d  = 1'b1;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = S_IDLE;
                end else if (bready_q && m_axi_bvalid) begin
                    bready_d = 1'b0;
                    addr_d   = addr_after_s;
                    rem_d    = rem_after_s;
                    if (rem_after_s == 32'd0) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        awlen_d     = calc_awlen(addr_after_s[11:3], rem_after_s);
                        awvalid_d   = 1'b1;
                        fetch_cnt_d = 9'd0;
                        state_d     = S_SEND_ADDR;
                    end
                end else begin
                    state_d = S_WAIT_RESP;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            addr_q        <= {AXI_ADDR_W{1'b0}};
            rem_q         <= 32'd0;
            awlen_q       <= 8'd0;
            awvalid_q     <= 1'b0;
            bready_q      <= 1'b0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
            error_q       <= 1'b0;
            buf_addr_q    <= {BUF_ADDR_W{1'b0}};
            fetch_cnt_q   <= 9'd0;
            sent_cnt_q    <= 8'd0;
            rd_inflight_q <= 1'b0;
            fifo_mem_q[0] <= {AXI_DATA_W{1'b0}};
            fifo_mem_q[1] <= {AXI_DATA_W{1'b0}};
            fifo_wr_q     <= 1'b0;
            fifo_rd_q     <= 1'b0;
            fifo_cnt_q    <= 2'd0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            rem_q         <= rem_d;
            awlen_q       <= awlen_d;
            awvalid_q     <= awvalid_d;
            bready_q      <= bready_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
            error_q       <= error_d;
            buf_addr_q    <= buf_addr_d;
            fetch_cnt_q   <= fetch_cnt_d;
            sent_cnt_q    <= sent_cnt_d;
            rd_inflight_q <= rd_inflight_d;
            fifo_mem_q    <= fifo_mem_d;
            fifo_wr_q     <= fifo_wr_d;
            fifo_rd_q     <= fifo_rd_d;
            fifo_cnt_q    <= fifo_cnt_d;
        end
    end
endmodule
